// File: rtl/hier_rr_merge_pkg.sv
// Shared sizing helpers and the channel index type for the hierarchical
// round-robin merge block and its per-channel FIFOs.
package hier_rr_merge_pkg;

  localparam int MAX_CH = 16;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int CH_IDX_W = idx_w(MAX_CH);

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

endpackage

// File: rtl/hier_rr_fifo.sv
// Per-channel FIFO with a registered occupancy count. The head word is
// visible one cycle after it is pushed, because there is no bypass path.
module hier_rr_fifo
  import hier_rr_merge_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  // Space and occupancy come only from the registered count. A pop in the
  // same cycle therefore never frees room for a push.
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign wr_en    = push & ~full;
  assign rd_en    = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + (PW+1)'(wr_en) - (PW+1)'(rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/hier_rr_merge.sv
// Merges NUM_CH buffered input channels into one registered valid/ready
// stream. A rotating-priority arbiter selects the source channel.
module hier_rr_merge
  import hier_rr_merge_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH*W-1:0]         in_data,
  output logic [NUM_CH-1:0]           in_ready,
  output logic                        out_valid,
  output logic [W-1:0]                out_data,
  output logic [idx_w(NUM_CH)-1:0]    out_ch,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            grant_cnt
);

  localparam int OCW = idx_w(NUM_CH);

  logic [NUM_CH-1:0] fifo_full, fifo_empty, fifo_pop;
  logic [W-1:0]      fifo_data [NUM_CH];

  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic [OCW-1:0]    out_ch_q, out_ch_d;
  logic [OCW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  grant_cnt_q, grant_cnt_d;

  logic              load;
  logic              grant_vld;
  ch_idx_t           grant_idx;
  logic [W-1:0]      grant_data;
  int                cand;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      hier_rr_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid[gi]),
        .push_data (in_data[gi*W +: W]),
        .pop       (fifo_pop[gi]),
        .pop_data  (fifo_data[gi]),
        .full      (fifo_full[gi]),
        .empty     (fifo_empty[gi])
      );

      assign fifo_pop[gi] = load & grant_vld & (grant_idx == ch_idx_t'(gi));
    end
  endgenerate

  assign in_ready = ~fifo_full;

  // The output register may take a new word when it is empty, or when the
  // word it holds leaves in this cycle.
  assign load = ~out_valid_q | out_ready;

  // Take the first non-empty channel, starting from rr_ptr and wrapping.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    cand       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      if (!grant_vld && !fifo_empty[cand]) begin
        grant_vld  = 1'b1;
        grant_idx  = ch_idx_t'(cand);
        grant_data = fifo_data[cand];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q + CNT_W'(out_valid_q & out_ready);
    if (load) begin
      if (grant_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_ch_d    = grant_idx[OCW-1:0];
        rr_ptr_d    = (int'(grant_idx) == NUM_CH - 1) ? '0 : OCW'(int'(grant_idx) + 1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_hier_rr_merge.sv
// Scoreboard bench for hier_rr_merge: per-channel expected-data queues are
// filled as words are driven and drained as output handshakes are observed.
module tb_hier_rr_merge;

  localparam int NUM_CH = 4;
  localparam int W      = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic                clk;
  logic                rst_n;
  logic [NUM_CH-1:0]   in_valid;
  logic [NUM_CH*W-1:0] in_data;
  logic [NUM_CH-1:0]   in_ready;
  logic                out_valid;
  logic [W-1:0]        out_data;
  logic [1:0]          out_ch;
  logic                out_ready;
  logic [CNT_W-1:0]    grant_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] sb [NUM_CH][$];
  int           exp_ch_q [$];

  hier_rr_merge #(
    .NUM_CH (NUM_CH),
    .W      (W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Output handshakes are observed on the falling edge, half a cycle before
  // the edge that completes them.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb[out_ch].size() == 0) begin
        chk("unexpected_out", {22'd0, out_ch, out_data}, 32'hDEAD);
      end else begin
        chk("out_data", {24'd0, out_data}, {24'd0, sb[out_ch].pop_front()});
      end
      if (exp_ch_q.size() > 0) begin
        chk("out_ch_seq", {30'd0, out_ch}, exp_ch_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    for (int c = 0; c < NUM_CH; c++) sb[c].delete();
    exp_ch_q.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    clear_sb();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_word(input int ch, input logic [W-1:0] d);
    in_valid     = '0;
    in_valid[ch] = 1'b1;
    in_data[ch*W +: W] = d;
    sb[ch].push_back(d);
    tick();
    in_valid = '0;
  endtask

  function automatic int sb_total();
    int t = 0;
    for (int c = 0; c < NUM_CH; c++) t += sb[c].size();
    return t;
  endfunction

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb_total() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb_total() != 0) chk("drain_timeout", sb_total(), 0);
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state and a single word on channel 2
    do_reset();
    chk("rst_in_ready", {28'd0, in_ready}, 32'hF);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_grant_cnt", {16'd0, grant_cnt}, 0);
    out_ready = 1'b1;
    push_word(2, 8'hA5);
    chk("no_bypass_valid", {31'd0, out_valid}, 0);
    tick();
    chk("single_valid", {31'd0, out_valid}, 1);
    chk("single_data", {24'd0, out_data}, 32'hA5);
    chk("single_ch", {30'd0, out_ch}, 2);
    tick();
    chk("single_cnt", {16'd0, grant_cnt}, 1);
    chk("single_idle", {31'd0, out_valid}, 0);

    // Round-robin fairness with every channel holding two words
    do_reset();
    for (int r = 0; r < 2; r++) begin
      in_valid = '1;
      for (int c = 0; c < NUM_CH; c++) begin
        in_data[c*W +: W] = W'(8'h10 * (r + 1) + c);
        sb[c].push_back(W'(8'h10 * (r + 1) + c));
      end
      tick();
    end
    in_valid = '0;
    tick();
    chk("rr_hold_valid", {31'd0, out_valid}, 1);
    chk("rr_hold_ch", {30'd0, out_ch}, 0);
    for (int i = 0; i < 8; i++) exp_ch_q.push_back(i % NUM_CH);
    out_ready = 1'b1;
    wait_empty(100);
    chk("rr_grant_cnt", {16'd0, grant_cnt}, 8);

    // Full FIFO refuses a further push
    do_reset();
    push_word(0, 8'h77);
    tick();
    for (int i = 0; i < DEPTH; i++) push_word(1, W'(8'hB0 + i));
    chk("full_in_ready", {28'd0, in_ready}, 32'hD);
    in_valid[1] = 1'b1;
    in_data[1*W +: W] = 8'hEE;
    tick();
    in_valid = '0;
    chk("full_refuse", {28'd0, in_ready}, 32'hD);
    out_ready = 1'b1;
    wait_empty(100);
    repeat (3) tick();
    chk("full_drained", {31'd0, out_valid}, 0);

    // Backpressure hold while other channels fill up
    do_reset();
    push_word(0, 8'h3C);
    tick();
    chk("bp_valid", {31'd0, out_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = '0;
      if (i < DEPTH) begin
        in_valid = 4'b1110;
        for (int c = 1; c < NUM_CH; c++) begin
          in_data[c*W +: W] = W'(8'h40 + i * 4 + c);
          sb[c].push_back(W'(8'h40 + i * 4 + c));
        end
      end
      tick();
      chk("bp_data", {24'd0, out_data}, 32'h3C);
      chk("bp_ch", {30'd0, out_ch}, 0);
    end
    in_valid = '0;
    chk("bp_no_pop", {28'd0, in_ready}, 32'h1);
    out_ready = 1'b1;
    wait_empty(100);

    // Pointer wrap-around on channel 3 at one word per cycle
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid    = '0;
      in_valid[3] = 1'b1;
      in_data[3*W +: W] = W'(8'hC0 + i);
      sb[3].push_back(W'(8'hC0 + i));
      tick();
      chk("wrap_ready", {31'd0, in_ready[3]}, 1);
    end
    in_valid = '0;
    wait_empty(100);
    chk("wrap_cnt", {16'd0, grant_cnt}, 10);

    // Asynchronous reset with three words buffered
    do_reset();
    in_valid = 4'b0111;
    in_data  = {8'h00, 8'h33, 8'h22, 8'h11};
    tick();
    in_valid = '0;
    tick();
    chk("async_pre_valid", {31'd0, out_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    clear_sb();
    chk("async_valid", {31'd0, out_valid}, 0);
    chk("async_data", {24'd0, out_data}, 0);
    chk("async_cnt", {16'd0, grant_cnt}, 0);
    chk("async_ready", {28'd0, in_ready}, 32'hF);
    repeat (2) tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      tick();
      chk("async_no_stale", {31'd0, out_valid}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hier_rr_merge.md
Name: hier_rr_merge

Overview:
- Parametrised multi-channel merge block: NUM_CH independent input channels, each buffered in its own FIFO sub-module instance.
- A round-robin arbiter drains the FIFOs into one registered valid/ready output stream.
- Serves as the next-generation hierarchical floorplan test design: the instance count, per-instance size and hierarchy depth scale with parameters.
- Carries real sequential state (FIFOs, arbiter pointer, counter) so each leaf has a non-trivial area.

Parameters:
- NUM_CH, 4, number of input channels and FIFO instances (2..16).
- W, 8, data width per channel.
- DEPTH, 4, entries per channel FIFO; power of two, >= 2.
- CNT_W, 16, width of the grant counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  NUM_CH  per-channel valid.
- in_data  input  NUM_CH*W  channel i occupies bits [i*W +: W].
- in_ready  output  NUM_CH  per-channel ready = FIFO not full.
- out_valid  output  1  output register holds data.
- out_data  output  W  output payload.
- out_ch  output  max(1,$clog2(NUM_CH))  source channel of out_data.
- out_ready  input  1  downstream accept.
- grant_cnt  output  CNT_W  total words delivered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All FIFO pointers and counts clear to 0, so in_ready is all ones.
  - out_valid, out_data, out_ch and grant_cnt clear to 0.
  - Round-robin pointer resets so channel 0 has highest priority.
  - Reset asserted mid-transfer discards all buffered data with no partial output.
- Push: channel i writes on an edge where in_valid[i] & in_ready[i].
  - in_ready[i] is derived from the registered count only: !full.
  - A pop in the same cycle does not free space for a push; a full FIFO refuses the push that cycle.
- FIFO:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - A count of 0..DEPTH disambiguates full and empty.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - No bypass: a word pushed into an empty FIFO is poppable only from the next cycle.
- Load condition: load = !out_valid | out_ready.
- On load, the arbiter searches channels starting at rr_ptr (rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CH) for the first non-empty FIFO.
  - If one is found: pop it, register out_data and out_ch, set out_valid=1, and set rr_ptr = granted channel + 1 (mod NUM_CH).
  - If none is found: out_valid=0 when out_ready, and rr_ptr is unchanged.
- Stability: while out_valid & !out_ready, out_data and out_ch hold stable and no pop occurs.
- Latency: a word accepted at edge E0 is at the head of its FIFO after E0 and appears on the output after edge E1 (one cycle) if the output is free.
- Throughput: one word per cycle sustained while out_ready=1.
- grant_cnt increments by 1 on every edge where out_valid & out_ready, and wraps at 2^CNT_W.
- Fairness: with all channels continuously non-empty, grants follow 0,1,...,NUM_CH-1,0,...

Decomposition:
- Package hier_rr_merge_pkg holds:
  - CH_IDX_W function/localparam.
  - Pointer-width helper.
  - Type for the channel index.
- Sub-module hier_rr_fifo, instantiated NUM_CH times in a generate loop:
  - Ports clk, rst_n, push, push_data, pop, pop_data, full, empty.
  - The instance count gives the fplan pass a scalable hierarchy.
- The arbiter stays inline in the top.

Test Plan:
- Reset and single word: apply reset, then push 0xA5 on ch2 at E0 with out_ready=1 -> in_ready=4'b1111 after reset; out_valid=1, out_data=0xA5, out_ch=2 after E1; grant_cnt=1 after E2.
- Round-robin fairness: pre-fill all 4 channels with 2 words each, with out_ready=0, then set out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3; grant_cnt=8.
- Full FIFO: push 4 words to ch1 with out_ready=0 -> in_ready[1]=0 after the 4th push. A further in_valid[1] is not accepted. Drain and verify exactly the 4 words arrive, in order.
- Backpressure hold: out_valid=1 with data 0x3C and out_ready=0 for 5 cycles, while other channels push -> out_data=0x3C and out_ch are stable; no FIFO count decreases.
- Wrap-around: push and pop 10 words through ch3 at 1 word/cycle -> pointers wrap past DEPTH; output order matches input order; grant_cnt=10.
- Async reset mid-stream: assert rst_n low between edges with 3 words buffered -> outputs go to 0 immediately without a clock edge; after release, no stale data appears.
